matrix_slot_manager: RTL and testbench
======================================

Name: matrix_slot_manager

Overview:
- Storage allocator and slot directory for the matrix BRAM.
- Directly downstream of the matrix-input stage: serves its alloc_req/alloc_valid handshake, reserves a slot and its BRAM region, and turns the commit pulse into a valid directory entry.
- Gives a registered query port to compute/display stages and supports explicit slot release.
- Evicts the oldest committed matrix when every slot is occupied.

Parameters:
- NUM_SLOTS, 8, number of matrix slots (2..16).
- ADDR_WIDTH, 9, BRAM address width; equals the codebase BRAM address width.
- REGION_SIZE, 25, elements reserved per slot (max dim 5x5).
- BASE_ADDR, 0, BRAM address of slot 0 region.
- SEQ_WIDTH, 16, commit-order sequence counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- alloc_req  in  1  level; held high until alloc_valid or alloc_fail is seen.
- alloc_m  in  4  requested rows.
- alloc_n  in  4  requested columns.
- alloc_valid  out  1  one-cycle grant pulse.
- alloc_fail  out  1  one-cycle refusal pulse.
- alloc_slot  out  4  granted slot; valid with alloc_valid.
- alloc_addr  out  ADDR_WIDTH  granted region base; valid with alloc_valid.
- commit_req  in  1  one-cycle commit pulse.
- commit_slot  in  4  slot being committed.
- commit_m  in  4  rows being committed.
- commit_n  in  4  columns being committed.
- commit_addr  in  ADDR_WIDTH  base address being committed.
- commit_error  out  1  one-cycle pulse on a rejected commit.
- release_req  in  1  one-cycle pulse: free release_slot.
- release_slot  in  4  slot to free.
- query_en  in  1  directory read strobe.
- query_slot  in  4  slot to read.
- query_hit  out  1  queried slot is VALID.
- query_m  out  4  queried slot rows.
- query_n  out  4  queried slot columns.
- query_addr  out  ADDR_WIDTH  queried slot base address.
- slot_count  out  5  number of VALID slots.

Behaviour:
- Directory entry per slot: status (FREE / RESERVED / VALID), m, n, seq[SEQ_WIDTH-1:0].
- Slot address is fixed: BASE_ADDR + slot*REGION_SIZE. It is computed in ADDR_WIDTH; out-of-range configuration is the integrator's responsibility.
- Reset: all entries FREE, seq counter 0, FSM IDLE, all outputs 0.
- Reset mid-scan or mid-grant: abandons the operation; no pulse is emitted.

Allocation FSM:
- IDLE:
  - If alloc_req=1, latch alloc_m and alloc_n.
  - Go to FAIL if m=0, n=0, or m*n>REGION_SIZE (8-bit product).
  - Otherwise go to SCAN with index 0, found=0, victim tracker cleared.
- SCAN:
  - Examines one slot per cycle, index 0..NUM_SLOTS-1.
  - The first FREE slot sets found/slot.
  - Among VALID slots, track the one with the smallest seq; ties go to the lowest index.
  - RESERVED slots are never candidates.
  - After the last index:
    - found → GRANT(slot).
    - Else a VALID victim exists → GRANT(victim).
    - Else → FAIL.
- GRANT:
  - alloc_valid=1 for exactly one cycle with alloc_slot and alloc_addr.
  - Entry becomes RESERVED with the latched m and n.
  - Then go to WAIT_DROP.
- FAIL: alloc_fail=1 for one cycle, then WAIT_DROP.
- WAIT_DROP: stay until alloc_req=0, then IDLE. A held-high request is never double-granted.
- Grant latency: 1 (IDLE) + NUM_SLOTS (SCAN) cycles after alloc_req rises; alloc_valid appears in the following cycle.

Commit, release and query:
- Commit is processed in any FSM state, in the cycle commit_req=1. It is accepted only if all hold:
  - the slot is RESERVED,
  - commit_m and commit_n equal the reserved dims,
  - commit_addr equals the slot base.
- Accepted commit: status VALID, seq ← counter, counter+1. The counter wraps modulo 2^SEQ_WIDTH; eviction order across a wrap is unspecified (documented limitation).
- Rejected commit: commit_error pulses the next cycle; the directory is unchanged.
- Release: RESERVED or VALID → FREE. FREE is a no-op.
- Release and commit to the same slot in the same cycle: release wins.
- A slot released while being scanned is seen with its post-update status from the next scanned index onward.
- Query: registered with 1-cycle latency. Outputs hold between strobes.
  - query_hit=0 for a non-VALID slot or for query_slot ≥ NUM_SLOTS; query_m, query_n, query_addr are still driven.
- slot_count: registered; updates the cycle after any status change.

Test Plan:
- Reset, then alloc_req with m=2, n=3 → alloc_valid exactly 10 cycles later (NUM_SLOTS=8), slot 0, addr 0. alloc_req dropped the next cycle → FSM returns to IDLE; slot 0 reads RESERVED.
- Commit slot 0, m=2, n=3, addr 0 → no commit_error. Query slot 0 → query_hit=1, 2/3/addr 0 one cycle later; slot_count=1.
- Eight successive alloc+commit cycles, then a ninth alloc with 1x1 → grant to slot 0 (oldest seq), addr 0; slot_count drops to 7.
- alloc_req with m=6, n=5 (30>25) or m=0 → alloc_fail pulse, no alloc_valid. alloc_req held high → no second pulse until it drops and rises again.
- Commit slot 2 with the wrong addr (e.g. 49 vs 50), or to a FREE slot → commit_error pulse; query_hit stays 0.
- All 8 slots RESERVED (never committed), then alloc → alloc_fail. Release slot 5, re-request → grant slot 5, addr 125.

Source files
------------

// File: rtl/matrix_slot_manager.sv
// Slot allocator and directory for matrix BRAM regions: scans one slot per cycle,
// grants the first free slot or evicts the oldest committed matrix.
module matrix_slot_manager #(
    parameter int NUM_SLOTS   = 8,
    parameter int ADDR_WIDTH  = 9,
    parameter int REGION_SIZE = 25,
    parameter int BASE_ADDR   = 0,
    parameter int SEQ_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    input  logic [3:0]            alloc_m,
    input  logic [3:0]            alloc_n,
    output logic                  alloc_valid,
    output logic                  alloc_fail,
    output logic [3:0]            alloc_slot,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic                  commit_req,
    input  logic [3:0]            commit_slot,
    input  logic [3:0]            commit_m,
    input  logic [3:0]            commit_n,
    input  logic [ADDR_WIDTH-1:0] commit_addr,
    output logic                  commit_error,
    input  logic                  release_req,
    input  logic [3:0]            release_slot,
    input  logic                  query_en,
    input  logic [3:0]            query_slot,
    output logic                  query_hit,
    output logic [3:0]            query_m,
    output logic [3:0]            query_n,
    output logic [ADDR_WIDTH-1:0] query_addr,
    output logic [4:0]            slot_count,
    output logic [2:0]            fsm_state
);
    localparam int             IDX_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [4:0]     SLOTS_5  = 5'(NUM_SLOTS);
    localparam logic [3:0]     LAST_IDX = 4'(NUM_SLOTS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_SCAN = 3'd1, S_GRANT = 3'd2, S_FAIL = 3'd3, S_WAIT_DROP = 3'd4
    } state_t;
    typedef enum logic [1:0] {ST_FREE = 2'd0, ST_RESERVED = 2'd1, ST_VALID = 2'd2} status_t;

    state_t               state, state_next;
    status_t              status  [NUM_SLOTS];
    logic [3:0]           dir_m   [NUM_SLOTS];
    logic [3:0]           dir_n   [NUM_SLOTS];
    logic [SEQ_WIDTH-1:0] dir_seq [NUM_SLOTS];
    logic [SEQ_WIDTH-1:0] seq_ctr;

    logic [3:0]           req_m, req_n, scan_idx, found_slot, victim_slot, grant_slot;
    logic                 found, victim_valid;
    logic [SEQ_WIDTH-1:0] victim_seq;
    logic                 found_nx, victim_valid_nx;
    logic [3:0]           found_slot_nx, victim_slot_nx;
    logic [SEQ_WIDTH-1:0] victim_seq_nx;
    logic [7:0]           dim_prod;
    logic                 dims_bad, commit_in_range, commit_ok, release_in_range, query_in_range;
    logic [IDX_W-1:0]     sidx, cidx, ridx, qidx, gidx;
    logic [4:0]           valid_count;

    function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [3:0] s);
        return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(s) * ADDR_WIDTH'(REGION_SIZE);
    endfunction

    assign fsm_state = state;
    assign sidx = scan_idx[IDX_W-1:0];
    assign cidx = commit_slot[IDX_W-1:0];
    assign ridx = release_slot[IDX_W-1:0];
    assign qidx = query_slot[IDX_W-1:0];
    assign grant_slot = found ? found_slot : victim_slot;
    assign gidx = grant_slot[IDX_W-1:0];

    assign dim_prod = {4'b0, alloc_m} * {4'b0, alloc_n};
    assign dims_bad = (alloc_m == 4'd0) || (alloc_n == 4'd0) || (dim_prod > 8'(REGION_SIZE));

    assign commit_in_range  = {1'b0, commit_slot} < SLOTS_5;
    assign release_in_range = {1'b0, release_slot} < SLOTS_5;
    assign query_in_range   = {1'b0, query_slot} < SLOTS_5;
    assign commit_ok = commit_in_range && (status[cidx] == ST_RESERVED) &&
                       (commit_m == dir_m[cidx]) && (commit_n == dir_n[cidx]) &&
                       (commit_addr == slot_base(commit_slot));

    // Candidate tracking for the slot under the scan pointer; RESERVED slots never qualify.
    always_comb begin
        found_nx        = found;
        found_slot_nx   = found_slot;
        victim_valid_nx = victim_valid;
        victim_slot_nx  = victim_slot;
        victim_seq_nx   = victim_seq;
        if (status[sidx] == ST_FREE && !found) begin
            found_nx      = 1'b1;
            found_slot_nx = scan_idx;
        end
        if (status[sidx] == ST_VALID && (!victim_valid || dir_seq[sidx] < victim_seq)) begin
            victim_valid_nx = 1'b1;
            victim_slot_nx  = scan_idx;
            victim_seq_nx   = dir_seq[sidx];
        end
    end

    always_comb begin
        valid_count = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (status[i] == ST_VALID) valid_count = valid_count + 5'd1;
    end

    // alloc_req is a level held by the requester until it sees one alloc_valid or
    // alloc_fail pulse; WAIT_DROP blocks a second answer until the level falls.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (alloc_req) state_next = dims_bad ? S_FAIL : S_SCAN;
            S_SCAN:      if (scan_idx == LAST_IDX)
                             state_next = (found_nx || victim_valid_nx) ? S_GRANT : S_FAIL;
            S_GRANT:     state_next = S_WAIT_DROP;
            S_FAIL:      state_next = S_WAIT_DROP;
            S_WAIT_DROP: if (!alloc_req) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_m <= '0; req_n <= '0; scan_idx <= '0;
            found <= 1'b0; found_slot <= '0;
            victim_valid <= 1'b0; victim_slot <= '0; victim_seq <= '0;
            alloc_valid <= 1'b0; alloc_fail <= 1'b0; alloc_slot <= '0; alloc_addr <= '0;
            commit_error <= 1'b0; seq_ctr <= '0;
            query_hit <= 1'b0; query_m <= '0; query_n <= '0; query_addr <= '0;
            slot_count <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                status[i] <= ST_FREE; dir_m[i] <= '0; dir_n[i] <= '0; dir_seq[i] <= '0;
            end
        end else begin
            alloc_valid  <= (state == S_GRANT);
            alloc_fail   <= (state == S_FAIL);
            commit_error <= commit_req && !commit_ok;
            slot_count   <= valid_count;

            if (state == S_IDLE && alloc_req) begin
                req_m <= alloc_m; req_n <= alloc_n; scan_idx <= '0;
                found <= 1'b0; found_slot <= '0;
                victim_valid <= 1'b0; victim_slot <= '0; victim_seq <= '0;
            end
            if (state == S_SCAN) begin
                scan_idx     <= scan_idx + 4'd1;
                found        <= found_nx;        found_slot  <= found_slot_nx;
                victim_valid <= victim_valid_nx; victim_slot <= victim_slot_nx;
                victim_seq   <= victim_seq_nx;
            end

            // Later assignments win: release overrides commit, a grant overrides both.
            if (commit_req && commit_ok) begin
                status[cidx]  <= ST_VALID;
                dir_seq[cidx] <= seq_ctr;
                seq_ctr       <= seq_ctr + 1'b1;
            end
            if (release_req && release_in_range) status[ridx] <= ST_FREE;
            if (state == S_GRANT) begin
                status[gidx] <= ST_RESERVED;
                dir_m[gidx]  <= req_m;
                dir_n[gidx]  <= req_n;
                alloc_slot   <= grant_slot;
                alloc_addr   <= slot_base(grant_slot);
            end

            if (query_en) begin
                query_addr <= slot_base(query_slot);
                if (query_in_range) begin
                    query_hit <= (status[qidx] == ST_VALID);
                    query_m   <= dir_m[qidx];
                    query_n   <= dir_n[qidx];
                end else begin
                    query_hit <= 1'b0;
                    query_m   <= '0;
                    query_n   <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_slot_manager.sv
// Bench for matrix_slot_manager: directed cases with literal expectations, then random
// traffic compared every cycle against a directory-level reference model.
`timescale 1ns/1ps
module tb_matrix_slot_manager;
    localparam int NS = 8;
    localparam int RS = 25;
    localparam int M_FREE = 0, M_RES = 1, M_VALID = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req, alloc_valid, alloc_fail;
    logic [3:0] alloc_m, alloc_n, alloc_slot;
    logic [8:0] alloc_addr;
    logic       commit_req, commit_error;
    logic [3:0] commit_slot, commit_m, commit_n;
    logic [8:0] commit_addr;
    logic       release_req;
    logic [3:0] release_slot;
    logic       query_en, query_hit;
    logic [3:0] query_slot, query_m, query_n;
    logic [8:0] query_addr;
    logic [4:0] slot_count;
    logic [2:0] fsm_state;

    always #5 clk = ~clk;

    matrix_slot_manager dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
        .alloc_valid(alloc_valid), .alloc_fail(alloc_fail),
        .alloc_slot(alloc_slot), .alloc_addr(alloc_addr),
        .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
        .commit_n(commit_n), .commit_addr(commit_addr), .commit_error(commit_error),
        .release_req(release_req), .release_slot(release_slot),
        .query_en(query_en), .query_slot(query_slot), .query_hit(query_hit),
        .query_m(query_m), .query_n(query_n), .query_addr(query_addr),
        .slot_count(slot_count), .fsm_state(fsm_state)
    );

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int base_of(input int s);
        return (s * RS) % 512;
    endfunction

    // Reference directory: status, dims and commit order per slot.
    int   m_st [NS];
    int   m_m  [NS];
    int   m_n  [NS];
    int   m_seq[NS];
    int   m_ctr, m_busy, m_lm, m_ln;
    bit   m_bad, m_drop;
    logic exp_valid, exp_fail, exp_cerr, exp_qhit;
    int   exp_qm, exp_qn, exp_qaddr, exp_count;
    logic [3:0] exp_q[$];

    // First free slot wins; otherwise the earliest-committed valid slot; otherwise none.
    function automatic int pick_slot();
        int best = -1;
        for (int i = 0; i < NS; i++) if (m_st[i] == M_FREE) return i;
        for (int i = 0; i < NS; i++)
            if (m_st[i] == M_VALID && (best < 0 || m_seq[i] < m_seq[best])) best = i;
        return best;
    endfunction

    function automatic bit commit_accept(input int s, input int cm, input int cn, input int ca);
        if (s >= NS) return 1'b0;
        return m_st[s] == M_RES && cm == m_m[s] && cn == m_n[s] && ca == base_of(s);
    endfunction

    always @(posedge clk) begin
        int vc, g, cs, qs;
        bit ok;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin m_st[i] = M_FREE; m_m[i] = 0; m_n[i] = 0; m_seq[i] = 0; end
            m_ctr = 0; m_busy = 0; m_drop = 0; m_bad = 0; m_lm = 0; m_ln = 0;
            exp_valid = 0; exp_fail = 0; exp_cerr = 0; exp_qhit = 0;
            exp_qm = 0; exp_qn = 0; exp_qaddr = 0; exp_count = 0;
            exp_q.delete();
        end else begin
            vc = 0;
            for (int i = 0; i < NS; i++) if (m_st[i] == M_VALID) vc++;
            exp_count = vc;
            exp_valid = 0; exp_fail = 0; g = -1;
            if (m_drop) begin
                if (!alloc_req) m_drop = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_drop = 1;
                    if (!m_bad) g = pick_slot();
                    if (g < 0) exp_fail = 1;
                    else begin exp_valid = 1; exp_q.push_back(4'(g)); end
                end
            end else if (alloc_req) begin
                m_lm = int'(alloc_m); m_ln = int'(alloc_n);
                m_bad = (m_lm == 0) || (m_ln == 0) || (m_lm * m_ln > RS);
                m_busy = m_bad ? 1 : NS + 1;
            end
            cs = int'(commit_slot);
            ok = commit_req && commit_accept(cs, int'(commit_m), int'(commit_n), int'(commit_addr));
            exp_cerr = commit_req && !ok;
            if (query_en) begin
                qs = int'(query_slot);
                exp_qaddr = base_of(qs);
                if (qs < NS) begin
                    exp_qhit = (m_st[qs] == M_VALID); exp_qm = m_m[qs]; exp_qn = m_n[qs];
                end else begin
                    exp_qhit = 0; exp_qm = 0; exp_qn = 0;
                end
            end
            if (ok) begin m_st[cs] = M_VALID; m_seq[cs] = m_ctr; m_ctr++; end
            if (release_req && int'(release_slot) < NS) m_st[int'(release_slot)] = M_FREE;
            if (g >= 0) begin m_st[g] = M_RES; m_m[g] = m_lm; m_n[g] = m_ln; end
        end
    end

    always @(negedge clk) begin
        logic [3:0] s;
        if (chk_on) begin
            check("alloc_valid", 32'(alloc_valid), 32'(exp_valid));
            check("alloc_fail", 32'(alloc_fail), 32'(exp_fail));
            check("commit_error", 32'(commit_error), 32'(exp_cerr));
            check("slot_count", 32'(slot_count), exp_count);
            check("query_hit", 32'(query_hit), 32'(exp_qhit));
            check("query_addr", 32'(query_addr), exp_qaddr);
            if (exp_qhit) begin
                check("query_m", 32'(query_m), exp_qm);
                check("query_n", 32'(query_n), exp_qn);
            end
            if (exp_valid && exp_q.size() > 0) begin
                s = exp_q.pop_front();
                check("alloc_slot", 32'(alloc_slot), 32'(s));
                check("alloc_addr", 32'(alloc_addr), base_of(int'(s)));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_alloc(input int m, input int n, input int hold, output bit got_v,
                            output bit got_f, output int slot, output int addr,
                            output int lat, output int extra);
        got_v = 0; got_f = 0; slot = 0; addr = 0; lat = 0; extra = 0;
        alloc_req = 1'b1; alloc_m = 4'(m); alloc_n = 4'(n);
        while (!got_v && !got_f && lat < 40) begin
            @(negedge clk);
            lat++;
            if (alloc_valid === 1'b1) begin got_v = 1; slot = int'(alloc_slot); addr = int'(alloc_addr); end
            if (alloc_fail === 1'b1) got_f = 1;
        end
        if (!got_v && !got_f) begin
            n_cmp++; n_fail++;
            $display("FAIL alloc_timeout: no pulse after %0d cycles, expected grant or refusal", lat);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (alloc_valid === 1'b1 || alloc_fail === 1'b1) extra++;
        end
        alloc_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_commit(input int s, input int m, input int n, input int a, output int err);
        commit_req = 1'b1; commit_slot = 4'(s); commit_m = 4'(m); commit_n = 4'(n); commit_addr = 9'(a);
        @(negedge clk);
        err = int'(commit_error);
        commit_req = 1'b0;
    endtask

    task automatic do_release(input int s);
        release_req = 1'b1; release_slot = 4'(s);
        @(negedge clk);
        release_req = 1'b0;
    endtask

    task automatic do_query(input int s, output int hit, output int qm, output int qn, output int qa);
        query_en = 1'b1; query_slot = 4'(s);
        @(negedge clk);
        hit = int'(query_hit); qm = int'(query_m); qn = int'(query_n); qa = int'(query_addr);
        query_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit gv, gf;
        int s, a, lat, extra, err, hit, qm, qn, qa, cm, cn, ca, rs;
        alloc_req = 0; alloc_m = 0; alloc_n = 0;
        commit_req = 0; commit_slot = 0; commit_m = 0; commit_n = 0; commit_addr = 0;
        release_req = 0; release_slot = 0; query_en = 0; query_slot = 0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        chk_on = 1'b1;
        check("reset_fsm_idle", 32'(fsm_state), 0);
        check("reset_slot_count", 32'(slot_count), 0);

        do_alloc(2, 3, 0, gv, gf, s, a, lat, extra);
        check("first_grant", 32'(gv), 1);
        check("first_latency", lat, 10);
        check("first_slot", s, 0);
        check("first_addr", a, 0);
        check("fsm_idle_after_drop", 32'(fsm_state), 0);
        do_query(0, hit, qm, qn, qa);
        check("reserved_no_hit", hit, 0);
        do_commit(0, 2, 3, 0, err);
        check("commit0_accepted", err, 0);
        do_query(0, hit, qm, qn, qa);
        check("q0_hit", hit, 1);
        check("q0_m", qm, 2);
        check("q0_n", qn, 3);
        check("q0_addr", qa, 0);
        check("count_one", 32'(slot_count), 1);

        for (int i = 1; i < NS; i++) begin
            do_alloc(1 + (i % 5), 2, 0, gv, gf, s, a, lat, extra);
            check("fill_slot", s, i);
            do_commit(i, 1 + (i % 5), 2, i * RS, err);
            check("fill_commit", err, 0);
        end
        idle(1);
        check("count_full", 32'(slot_count), 8);
        do_alloc(1, 1, 0, gv, gf, s, a, lat, extra);
        check("evict_slot", s, 0);
        check("evict_addr", a, 0);
        check("count_after_evict", 32'(slot_count), 7);
        do_commit(0, 1, 1, 0, err);
        check("recommit0", err, 0);

        do_alloc(6, 5, 0, gv, gf, s, a, lat, extra);
        check("fail_big", 32'(gf), 1);
        check("fail_big_no_grant", 32'(gv), 0);
        check("fail_latency", lat, 2);
        do_alloc(0, 3, 0, gv, gf, s, a, lat, extra);
        check("fail_zero", 32'(gf), 1);
        do_alloc(6, 5, 6, gv, gf, s, a, lat, extra);
        check("held_no_repeat", extra, 0);

        do_release(2);
        do_alloc(2, 2, 0, gv, gf, s, a, lat, extra);
        check("realloc_slot2", s, 2);
        check("realloc_addr2", a, 50);
        do_commit(2, 2, 2, 49, err);
        check("commit_bad_addr", err, 1);
        do_query(2, hit, qm, qn, qa);
        check("bad_commit_no_hit", hit, 0);
        do_release(3);
        do_commit(3, 2, 2, 75, err);
        check("commit_free_slot", err, 1);

        do_reset();
        for (int i = 0; i < NS; i++) begin
            do_alloc(3, 3, 0, gv, gf, s, a, lat, extra);
            check("reserve_all", s, i);
        end
        do_alloc(1, 1, 0, gv, gf, s, a, lat, extra);
        check("all_reserved_fail", 32'(gf), 1);
        do_release(5);
        do_alloc(3, 3, 0, gv, gf, s, a, lat, extra);
        check("regrant_slot5", s, 5);
        check("regrant_addr5", a, 125);

        alloc_req = 1'b1; alloc_m = 4'd2; alloc_n = 4'd2;
        idle(4);
        rst = 1'b1; alloc_req = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(14);
        check("midscan_reset_idle", 32'(fsm_state), 0);

        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 5))
                0: do_alloc($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 2),
                            gv, gf, s, a, lat, extra);
                1: begin
                    s = $urandom_range(0, NS - 1);
                    for (int j = 0; j < NS; j++)
                        if (m_st[(s + j) % NS] == M_RES) begin s = (s + j) % NS; break; end
                    cm = m_m[s]; cn = m_n[s]; ca = base_of(s);
                    case ($urandom_range(0, 5))
                        0: ca = (ca + 1) % 512;
                        1: cm = (cm + 1) % 16;
                        default: ;
                    endcase
                    do_commit(s, cm, cn, ca, err);
                end
                2: do_release($urandom_range(0, NS));
                3: do_query($urandom_range(0, 15), hit, qm, qn, qa);
                4: begin
                    s = $urandom_range(0, NS - 1);
                    rs = $urandom_range(0, 1) ? s : $urandom_range(0, NS - 1);
                    commit_req = 1'b1; commit_slot = 4'(s); commit_m = 4'(m_m[s]);
                    commit_n = 4'(m_n[s]); commit_addr = 9'(base_of(s));
                    release_req = 1'b1; release_slot = 4'(rs);
                    query_en = 1'b1; query_slot = 4'($urandom_range(0, NS - 1));
                    @(negedge clk);
                    commit_req = 1'b0; release_req = 1'b0; query_en = 1'b0;
                end
                default: idle($urandom_range(1, 3));
            endcase
        end
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
